// File: rtl/risc_control_unit_pkg.sv
// Shared encodings for the 8-bit RISC control unit: opcodes, FSM states, bus selects, IR fields.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package risc_control_unit_pkg;

  // Instruction field positions inside the IR
  localparam int OP_MSB   = 7;
  localparam int OP_LSB   = 4;
  localparam int SRC_MSB  = 3;
  localparam int SRC_LSB  = 2;
  localparam int DEST_MSB = 1;
  localparam int DEST_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_NOT = 4'd4,
    OP_RD  = 4'd5,
    OP_WR  = 4'd6,
    OP_BR  = 4'd7,
    OP_BRZ = 4'd8
  } opcode_e;

  // Encodings 12..15 are unreachable and recover to S_IDLE
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FET1 = 4'd1,
    S_FET2 = 4'd2,
    S_DEC  = 4'd3,
    S_EX1  = 4'd4,
    S_RD1  = 4'd5,
    S_RD2  = 4'd6,
    S_WR1  = 4'd7,
    S_WR2  = 4'd8,
    S_BR1  = 4'd9,
    S_BR2  = 4'd10,
    S_HALT = 4'd11
  } state_e;

  // Bus_1 sources: 0..3 select R0..R3 directly
  localparam logic [2:0] BUS1_PC = 3'd4;

  localparam logic [1:0] BUS2_ALU  = 2'd0;
  localparam logic [1:0] BUS2_BUS1 = 2'd1;
  localparam logic [1:0] BUS2_MEM  = 2'd2;

endpackage

// File: rtl/risc_control_unit.sv
// Multi-cycle control FSM for the 8-bit RISC machine; sole source of datapath strobes and bus selects.
// Latency: outputs are combinational from the current state and IR; one state step per clock.
// Backpressure: none; the datapath always accepts the strobes issued each cycle.
module risc_control_unit
  import risc_control_unit_pkg::*;
#(
  parameter int word_size  = 8,
  parameter int op_size    = 4,
  parameter int state_size = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_size-1:0]  instruction,
  input  logic                  zero_flag,
  output logic [3:0]            load_reg,
  output logic                  load_pc,
  output logic                  inc_pc,
  output logic                  load_ir,
  output logic                  load_add_r,
  output logic                  load_reg_y,
  output logic                  load_reg_z,
  output logic [2:0]            bus1_sel,
  output logic [1:0]            bus2_sel,
  output logic                  mem_write,
  output logic                  halted,
  output logic [state_size-1:0] state
);

  logic [op_size-1:0]    opcode;
  logic [1:0]            src;
  logic [1:0]            dest;
  logic [state_size-1:0] state_q;
  logic [state_size-1:0] state_d;

  assign opcode = instruction[OP_MSB:OP_LSB];
  assign src    = instruction[SRC_MSB:SRC_LSB];
  assign dest   = instruction[DEST_MSB:DEST_LSB];
  assign state  = state_q;

  // State register; reset takes effect immediately so an aborted instruction leaves no strobe behind
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state sequencing from the current state, opcode and zero flag
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: state_d = S_FET1;
      S_FET1: state_d = S_FET2;
      S_FET2: state_d = S_DEC;
      S_DEC: begin
        case (opcode)
          OP_NOP, OP_NOT:         state_d = S_FET1;
          OP_ADD, OP_SUB, OP_AND: state_d = S_EX1;
          OP_RD:                  state_d = S_RD1;
          OP_WR:                  state_d = S_WR1;
          OP_BR:                  state_d = S_BR1;
          OP_BRZ:                 state_d = zero_flag ? S_BR1 : S_FET1;
          default:                state_d = S_HALT;
        endcase
      end
      S_EX1:  state_d = S_FET1;
      S_RD1:  state_d = S_RD2;
      S_RD2:  state_d = S_FET1;
      S_WR1:  state_d = S_WR2;
      S_WR2:  state_d = S_FET1;
      S_BR1:  state_d = S_BR2;
      S_BR2:  state_d = S_FET1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; every strobe and select defaults to 0 so idle and unknown states are quiet
  always_comb begin
    load_reg   = 4'b0000;
    load_pc    = 1'b0;
    inc_pc     = 1'b0;
    load_ir    = 1'b0;
    load_add_r = 1'b0;
    load_reg_y = 1'b0;
    load_reg_z = 1'b0;
    bus1_sel   = 3'd0;
    bus2_sel   = BUS2_ALU;
    mem_write  = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_FET1: begin
        bus1_sel   = BUS1_PC;
        bus2_sel   = BUS2_BUS1;
        load_add_r = 1'b1;
        inc_pc     = 1'b1;
      end
      S_FET2: begin
        bus2_sel = BUS2_MEM;
        load_ir  = 1'b1;
      end
      S_DEC: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND: begin
            bus1_sel   = {1'b0, src};
            bus2_sel   = BUS2_BUS1;
            load_reg_y = 1'b1;
          end
          OP_NOT: begin
            bus1_sel   = {1'b0, src};
            bus2_sel   = BUS2_ALU;
            load_reg_z = 1'b1;
            load_reg   = 4'b0001 << dest;
          end
          OP_RD, OP_WR, OP_BR: begin
            bus1_sel   = BUS1_PC;
            bus2_sel   = BUS2_BUS1;
            load_add_r = 1'b1;
          end
          OP_BRZ: begin
            if (zero_flag) begin
              bus1_sel   = BUS1_PC;
              bus2_sel   = BUS2_BUS1;
              load_add_r = 1'b1;
            end else begin
              // Untaken branch: step the PC over the address byte
              inc_pc = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_EX1: begin
        bus1_sel   = {1'b0, dest};
        bus2_sel   = BUS2_ALU;
        load_reg_z = 1'b1;
        load_reg   = 4'b0001 << dest;
      end
      S_RD1, S_WR1: begin
        bus2_sel   = BUS2_MEM;
        load_add_r = 1'b1;
        inc_pc     = 1'b1;
      end
      S_RD2: begin
        bus2_sel = BUS2_MEM;
        load_reg = 4'b0001 << dest;
      end
      S_WR2: begin
        bus1_sel  = {1'b0, src};
        mem_write = 1'b1;
      end
      S_BR1: begin
        bus2_sel   = BUS2_MEM;
        load_add_r = 1'b1;
      end
      S_BR2: begin
        bus2_sel = BUS2_MEM;
        load_pc  = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_risc_control_unit.sv
// Self-checking bench for risc_control_unit: per-instruction expected control traces plus invariants.
// Latency: n/a.
// Backpressure: n/a.
module tb_risc_control_unit;
  import risc_control_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] instruction = 8'h00;
  logic       zero_flag = 1'b0;
  logic [3:0] load_reg;
  logic       load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z;
  logic [2:0] bus1_sel;
  logic [1:0] bus2_sel;
  logic       mem_write, halted;
  logic [3:0] state;

  risc_control_unit dut (
    .clk(clk), .rst(rst), .instruction(instruction), .zero_flag(zero_flag),
    .load_reg(load_reg), .load_pc(load_pc), .inc_pc(inc_pc), .load_ir(load_ir),
    .load_add_r(load_add_r), .load_reg_y(load_reg_y), .load_reg_z(load_reg_z),
    .bus1_sel(bus1_sel), .bus2_sel(bus2_sel), .mem_write(mem_write),
    .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  // One cycle's worth of control outputs
  typedef struct packed {
    logic [3:0] st;
    logic [3:0] lreg;
    logic       lpc, ipc, lir, lar, ly, lz;
    logic [2:0] b1;
    logic [1:0] b2;
    logic       mw, hlt;
  } ctl_t;

  int   vectors     = 0;
  int   miscompares = 0;
  ctl_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ctl_t observed();
    ctl_t c;
    c.st = state;  c.lreg = load_reg;
    c.lpc = load_pc; c.ipc = inc_pc; c.lir = load_ir; c.lar = load_add_r;
    c.ly = load_reg_y; c.lz = load_reg_z;
    c.b1 = bus1_sel; c.b2 = bus2_sel; c.mw = mem_write; c.hlt = halted;
    return c;
  endfunction

  function automatic ctl_t quiet(input logic [3:0] st);
    ctl_t c;
    c = '0;
    c.st = st;
    return c;
  endfunction

  // PC onto Bus_1, through to Bus_2, into the address register
  function automatic ctl_t addr_cyc(input logic [3:0] st);
    ctl_t c;
    c = quiet(st);
    c.b1 = 3'd4; c.b2 = 2'd1; c.lar = 1'b1;
    return c;
  endfunction

  task automatic check_invariants();
    check("pc_load_and_inc", 32'(load_pc & inc_pc), 32'd0);
    check("load_reg_onehot0", 32'($countones(load_reg) <= 1), 32'd1);
    check("bus1_range", 32'(bus1_sel <= 3'd4), 32'd1);
    check("bus2_range", 32'(bus2_sel <= 2'd2), 32'd1);
    check("mem_write_only_wr2", 32'(mem_write && (state != S_WR2)), 32'd0);
  endtask

  // Expected cycle-by-cycle trace of one whole instruction, fetch included
  task automatic build_trace(input logic [7:0] ins, input logic zf, output logic will_halt);
    int         op;
    logic [1:0] s, d;
    ctl_t       c;
    op = int'(ins >> 4);
    s  = 2'((ins >> 2) & 8'h3);
    d  = 2'(ins & 8'h3);
    will_halt = 1'b0;
    exp_q.delete();
    c = addr_cyc(S_FET1); c.ipc = 1'b1; exp_q.push_back(c);
    c = quiet(S_FET2); c.b2 = 2'd2; c.lir = 1'b1; exp_q.push_back(c);
    c = quiet(S_DEC);
    if (op == 0) begin
      exp_q.push_back(c);
    end else if (op >= 1 && op <= 3) begin
      c.b1 = {1'b0, s}; c.b2 = 2'd1; c.ly = 1'b1; exp_q.push_back(c);
      c = quiet(S_EX1); c.b1 = {1'b0, d}; c.lz = 1'b1; c.lreg = 4'(1) << d;
      exp_q.push_back(c);
    end else if (op == 4) begin
      c.b1 = {1'b0, s}; c.lz = 1'b1; c.lreg = 4'(1) << d; exp_q.push_back(c);
    end else if (op == 5 || op == 6 || op == 7 || (op == 8 && zf)) begin
      exp_q.push_back(addr_cyc(S_DEC));
      if (op == 5) begin
        c = quiet(S_RD1); c.b2 = 2'd2; c.lar = 1'b1; c.ipc = 1'b1; exp_q.push_back(c);
        c = quiet(S_RD2); c.b2 = 2'd2; c.lreg = 4'(1) << d; exp_q.push_back(c);
      end else if (op == 6) begin
        c = quiet(S_WR1); c.b2 = 2'd2; c.lar = 1'b1; c.ipc = 1'b1; exp_q.push_back(c);
        c = quiet(S_WR2); c.b1 = {1'b0, s}; c.mw = 1'b1; exp_q.push_back(c);
      end else begin
        c = quiet(S_BR1); c.b2 = 2'd2; c.lar = 1'b1; exp_q.push_back(c);
        c = quiet(S_BR2); c.b2 = 2'd2; c.lpc = 1'b1; exp_q.push_back(c);
      end
    end else if (op == 8) begin
      c.ipc = 1'b1; exp_q.push_back(c);
    end else begin
      exp_q.push_back(c);
      will_halt = 1'b1;
    end
  endtask

  // Called about 1 time unit after a falling edge; returns on a falling edge with DUT in S_FET1
  task automatic apply_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", 32'(observed()), 32'(quiet(S_IDLE)));
    @(negedge clk);
    #1;
    check("rst_hold", 32'(observed()), 32'(quiet(S_IDLE)));
    rst = 1'b0;
    #1;
    check("idle_after_rst", 32'(observed()), 32'(quiet(S_IDLE)));
    @(negedge clk);
  endtask

  // Entered on a falling edge with DUT in S_FET1; abort_at aborts via reset after that cycle
  task automatic run_instr(input logic [7:0] ins, input logic zf, input int abort_at);
    logic will_halt;
    build_trace(ins, zf, will_halt);
    instruction = ins;
    zero_flag   = zf;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check($sformatf("ctl_%02h_z%0d_c%0d", ins, zf, i), 32'(observed()), 32'(exp_q[i]));
      check_invariants();
      if (i == abort_at) begin
        apply_reset();
        return;
      end
    end
    if (will_halt) begin
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        #1;
        check($sformatf("halt_%02h_c%0d", ins, k), 32'(observed()),
              32'({S_HALT, 16'h0000, 1'b1}));
      end
      apply_reset();
    end else begin
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] op;
    int         abort_at;
    #1;
    apply_reset();
    run_instr(8'h1B, 1'b0, -1);
    run_instr(8'h80, 1'b0, -1);
    run_instr(8'h80, 1'b1, -1);
    run_instr(8'h64, 1'b0, -1);
    run_instr(8'h64, 1'b0, 3);
    run_instr(8'h5E, 1'b1, -1);
    run_instr(8'h47, 1'b0, -1);
    run_instr(8'h00, 1'b1, -1);
    run_instr(8'hF0, 1'b0, -1);
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 19) == 0) op = 4'($urandom_range(9, 15));
      else                            op = 4'($urandom_range(0, 8));
      abort_at = ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr({op, 4'($urandom_range(0, 15))}, 1'($urandom_range(0, 1)), abort_at);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
